// File: rtl/cache_miss_engine_if.sv
// Cache-to-engine miss/refill handshake and engine-to-memory request bus.
// The master modport is the miss engine; the slave modport is the cache plus main memory.
interface cache_miss_engine_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              miss_valid;
    logic              miss_ready;
    logic [ADDR_W-1:0] miss_addr;
    logic              victim_dirty;
    logic [ADDR_W-1:0] victim_addr;
    logic [DATA_W-1:0] victim_data;
    logic              fill_valid;
    logic              fill_err;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport master (
        input  miss_valid, miss_addr, victim_dirty, victim_addr, victim_data,
        input  mem_ack, mem_rdata,
        output miss_ready, fill_valid, fill_err, fill_addr, fill_data,
        output mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        output miss_valid, miss_addr, victim_dirty, victim_addr, victim_data,
        output mem_ack, mem_rdata,
        input  miss_ready, fill_valid, fill_err, fill_addr, fill_data,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/cache_miss_engine.sv
// Miss handler for a direct-mapped one-word-line cache: optional dirty write-back,
// then a word fetch, reported to the cache as a one-cycle fill strobe.
module cache_miss_engine #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    cache_miss_engine_if.master bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB    = 3'd1,
        FILL  = 3'd2,
        RESP  = 3'd3,
        ABORT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            state_q;
    logic [ADDR_W-1:0] miss_addr_q;
    logic [ADDR_W-1:0] victim_addr_q;
    logic [DATA_W-1:0] victim_data_q;
    logic [DATA_W-1:0] fill_data_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              timeout_hit;

    // A zero TIMEOUT lets the counter wrap harmlessly and never aborts.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            miss_addr_q   <= '0;
            victim_addr_q <= '0;
            victim_data_q <= '0;
            fill_data_q   <= '0;
            wait_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wait_cnt_q <= '0;
                    if (bus.miss_valid) begin
                        miss_addr_q   <= bus.miss_addr & ALIGN_MASK;
                        victim_addr_q <= bus.victim_addr & ALIGN_MASK;
                        victim_data_q <= bus.victim_data;
                        state_q       <= bus.victim_dirty ? WB : FILL;
                    end
                end
                WB, FILL: begin
                    if (bus.mem_ack) begin
                        wait_cnt_q <= '0;
                        if (state_q == FILL) begin
                            fill_data_q <= bus.mem_rdata;
                            state_q     <= RESP;
                        end else begin
                            state_q <= FILL;
                        end
                    end else if (timeout_hit) begin
                        // A write-back timeout skips the fetch; the cache retries the miss.
                        wait_cnt_q <= '0;
                        state_q    <= ABORT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                RESP, ABORT: begin
                    wait_cnt_q <= '0;
                    state_q    <= IDLE;
                end
                default: begin
                    wait_cnt_q <= '0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    // Every output decodes registered state only, so reset drops mem_req without a clock edge.
    assign bus.miss_ready = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.mem_req    = (state_q == WB) || (state_q == FILL);
    assign bus.mem_we     = (state_q == WB);
    assign bus.mem_addr   = (state_q == WB) ? victim_addr_q : miss_addr_q;
    assign bus.mem_wdata  = victim_data_q;
    assign bus.fill_valid = (state_q == RESP) || (state_q == ABORT);
    assign bus.fill_err   = (state_q == ABORT);
    assign bus.fill_addr  = miss_addr_q;
    assign bus.fill_data  = fill_data_q;
endmodule

// File: tb/tb_cache_miss_engine.sv
// Directed bench for cache_miss_engine with a queue scoreboard for memory and fill traffic.
module tb_cache_miss_engine;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    cache_miss_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cache_miss_engine #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(4),
        .CNT_W  (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_txn_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
    } fill_t;

    mem_txn_t      exp_mem[$];
    fill_t         exp_fill[$];
    bit            mem_auto      = 1'b1;
    int            ack_wait      = 0;
    bit            spurious      = 1'b0;
    bit            use_addr_data = 1'b0;
    logic [DW-1:0] rdata_val     = '0;
    logic [DW-1:0] model_fill    = '0;
    int            fills_seen    = 0;
    int            wcnt          = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder: acks after ack_wait idle request cycles, scoreboards each accepted request.
    initial begin
        mem_txn_t e;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1 && mem_auto && reset === 1'b0) begin
                if (wcnt >= ack_wait) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = use_addr_data ? ~bus.mem_addr : rdata_val;
                    wcnt = 0;
                    $display("mem txn: we=%0b addr=%h wdata=%h", bus.mem_we, bus.mem_addr, bus.mem_wdata);
                    check("mem_pending", {63'd0, exp_mem.size() != 0}, 64'd1);
                    if (exp_mem.size() != 0) begin
                        e = exp_mem.pop_front();
                        check("mem_we", {63'd0, bus.mem_we}, {63'd0, e.we});
                        check("mem_addr", {32'd0, bus.mem_addr}, {32'd0, e.addr});
                        if (e.we) check("mem_wdata", {32'd0, bus.mem_wdata}, {32'd0, e.wdata});
                    end
                end else begin
                    bus.mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                bus.mem_ack = spurious;
                wcnt = 0;
            end
        end
    end

    // Fill monitor: every strobe must match the oldest expected fill.
    initial begin
        fill_t f;
        forever begin
            @(negedge clk);
            if (bus.fill_valid === 1'b1) begin
                fills_seen++;
                $display("fill: addr=%h data=%h err=%0b", bus.fill_addr, bus.fill_data, bus.fill_err);
                check("fill_pending", {63'd0, exp_fill.size() != 0}, 64'd1);
                if (exp_fill.size() != 0) begin
                    f = exp_fill.pop_front();
                    check("fill_addr", {32'd0, bus.fill_addr}, {32'd0, f.addr});
                    check("fill_err", {63'd0, bus.fill_err}, {63'd0, f.err});
                    check("fill_data", {32'd0, bus.fill_data}, {32'd0, f.data});
                end
            end
        end
    end

    // mode 1: completes normally, 2: times out, 0: abandoned by reset.
    task automatic push_expect(input logic [AW-1:0] addr, input logic dirty,
                               input logic [AW-1:0] vaddr, input logic [DW-1:0] vdata,
                               input int mode);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = addr & ~32'd3;
        if (mode == 1) begin
            if (dirty) exp_mem.push_back('{we: 1'b1, addr: vaddr & ~32'd3, wdata: vdata});
            exp_mem.push_back('{we: 1'b0, addr: a, wdata: '0});
            d = use_addr_data ? ~a : rdata_val;
            model_fill = d;
            exp_fill.push_back('{addr: a, data: d, err: 1'b0});
        end else if (mode == 2) begin
            exp_fill.push_back('{addr: a, data: model_fill, err: 1'b1});
        end
    endtask

    // Returns just after the accepting edge.
    task automatic send_miss(input logic [AW-1:0] addr, input logic dirty,
                             input logic [AW-1:0] vaddr, input logic [DW-1:0] vdata,
                             input int mode);
        int n = 0;
        @(negedge clk);
        while (bus.miss_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("miss_ready_wait", {63'd0, bus.miss_ready}, 64'd1);
        bus.miss_valid   = 1'b1;
        bus.miss_addr    = addr;
        bus.victim_dirty = dirty;
        bus.victim_addr  = vaddr;
        bus.victim_data  = vdata;
        push_expect(addr, dirty, vaddr, vdata, mode);
        @(posedge clk);
        #1;
        bus.miss_valid = 1'b0;
    endtask

    task automatic wait_fills(input int target);
        int n = 0;
        while (fills_seen < target && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("fill_count", 64'(fills_seen), 64'(target));
    endtask

    initial begin
        int req_hi;
        int gap;
        int n;
        int fills_before;
        reset            = 1'b1;
        bus.miss_valid   = 1'b0;
        bus.miss_addr    = '0;
        bus.victim_dirty = 1'b0;
        bus.victim_addr  = '0;
        bus.victim_data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_miss_ready", {63'd0, bus.miss_ready}, 64'd1);
        check("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
        check("rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
        check("rst_fill_valid", {63'd0, bus.fill_valid}, 64'd0);
        check("rst_fill_err", {63'd0, bus.fill_err}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_fill_data", {32'd0, bus.fill_data}, 64'd0);
        check("rst_mem_addr", {32'd0, bus.mem_addr}, 64'd0);
        reset = 1'b0;

        // Clean miss, zero-wait memory
        mem_auto = 1'b1; ack_wait = 0; rdata_val = 32'hDEADBEEF;
        send_miss(32'h0000_1236, 1'b0, '0, '0, 1);
        @(negedge clk);
        check("clean_ready_low", {63'd0, bus.miss_ready}, 64'd0);
        check("clean_req", {63'd0, bus.mem_req}, 64'd1);
        check("clean_rd_addr", {32'd0, bus.mem_addr}, 64'h1234);
        @(negedge clk);
        check("clean_fill_valid", {63'd0, bus.fill_valid}, 64'd1);
        check("clean_fill_addr", {32'd0, bus.fill_addr}, 64'h1234);
        check("clean_req_drop", {63'd0, bus.mem_req}, 64'd0);
        @(negedge clk);
        check("clean_ready_back", {63'd0, bus.miss_ready}, 64'd1);
        check("clean_fill_once", {63'd0, bus.fill_valid}, 64'd0);
        wait_fills(1);

        // Dirty miss, 3 wait cycles per request
        ack_wait = 3; rdata_val = 32'h1234_5678;
        send_miss(32'h0080_2000, 1'b1, 32'h0040_2000, 32'hCAFEF00D, 1);
        req_hi = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) req_hi++;
        end
        check("dirty_req_held", 64'(req_hi), 64'd8);
        @(negedge clk);
        check("dirty_fill_valid", {63'd0, bus.fill_valid}, 64'd1);
        wait_fills(2);

        // Timeout with no memory response
        mem_auto = 1'b0;
        send_miss(32'h0000_0100, 1'b0, '0, '0, 2);
        req_hi = 0; n = 0;
        while (bus.fill_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            if (bus.fill_valid !== 1'b1 && bus.mem_req === 1'b1) req_hi++;
            n++;
        end
        check("to_req_cycles", 64'(req_hi), 64'd5);
        check("to_fill_err", {63'd0, bus.fill_err}, 64'd1);
        check("to_req_low", {63'd0, bus.mem_req}, 64'd0);
        @(negedge clk);
        check("to_fill_once", {63'd0, bus.fill_valid}, 64'd0);
        check("to_idle", {63'd0, bus.miss_ready}, 64'd1);
        mem_auto = 1'b1; ack_wait = 0;
        wait_fills(3);

        // Spurious acks in IDLE and RESP
        spurious = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("spur_idle_busy", {63'd0, bus.busy}, 64'd0);
        check("spur_idle_req", {63'd0, bus.mem_req}, 64'd0);
        check("spur_idle_fill", 64'(fills_seen), 64'd3);
        rdata_val = 32'h0BAD_F00D;
        send_miss(32'h0000_2000, 1'b0, '0, '0, 1);
        repeat (4) @(negedge clk);
        #1;
        check("spur_fill_count", 64'(fills_seen), 64'd4);
        check("spur_busy", {63'd0, bus.busy}, 64'd0);
        check("spur_req", {63'd0, bus.mem_req}, 64'd0);
        spurious = 1'b0;

        // Reset two cycles into a FILL wait
        ack_wait = 10;
        send_miss(32'h0000_3000, 1'b0, '0, '0, 0);
        @(negedge clk);
        check("rstmid_req_a", {63'd0, bus.mem_req}, 64'd1);
        @(negedge clk);
        check("rstmid_req_b", {63'd0, bus.mem_req}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rstmid_req_drop", {63'd0, bus.mem_req}, 64'd0);
        check("rstmid_busy", {63'd0, bus.busy}, 64'd0);
        model_fill = '0;
        fills_before = fills_seen;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rstmid_no_fill", 64'(fills_seen), 64'(fills_before));
        check("rstmid_fill_data", {32'd0, bus.fill_data}, 64'd0);
        ack_wait = 0; rdata_val = 32'h5555_AAAA;
        send_miss(32'h0000_4444, 1'b0, '0, '0, 1);
        wait_fills(5);

        // Back-to-back with miss_valid held high
        use_addr_data = 1'b1;
        @(negedge clk);
        bus.miss_valid   = 1'b1;
        bus.miss_addr    = 32'h0001_0008;
        bus.victim_dirty = 1'b0;
        push_expect(32'h0001_0008, 1'b0, '0, '0, 1);
        @(posedge clk);
        #1;
        bus.miss_addr = 32'h0002_000D;
        push_expect(32'h0002_000D, 1'b0, '0, '0, 1);
        gap = 0; n = 0;
        @(negedge clk);
        while (bus.miss_ready !== 1'b1 && n < 20) begin
            gap++;
            @(negedge clk);
            n++;
        end
        check("b2b_gap", 64'(gap), 64'd2);
        @(posedge clk);
        #1;
        bus.miss_valid = 1'b0;
        wait_fills(7);

        check("mem_queue_empty", 64'(exp_mem.size()), 64'd0);
        check("fill_queue_empty", 64'(exp_fill.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
